mq_static_fifo: RTL and testbench

MQ_STATIC_FIFO -- requirements
Module: mq_static_fifo

---
 rtl/mq_static_fifo.sv | 147 ++++++++++++++
 tb/tb_mq_static_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mq_static_fifo.sv
// Multi-queue FIFO with statically partitioned storage: NUMFIFO queues of NUMELEM entries
// sharing one memory, with per-queue head/count, registered status and pipelined pop data.
module mq_static_fifo #(
    parameter int unsigned NUMELEM   = 4,
    parameter int unsigned BITDATA   = 8,
    parameter int unsigned NUMFIFO   = 8,
    parameter int unsigned DAT_DELAY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic                       push,
    input  logic [$clog2(NUMFIFO)-1:0] pu_prt,
    input  logic [BITDATA-1:0]         pu_din,
    input  logic                       pop,
    input  logic [$clog2(NUMFIFO)-1:0] po_prt,
    output logic                       po_vld,
    output logic [BITDATA-1:0]         po_dout,
    output logic                       pu_err,
    output logic                       po_err,
    output logic [NUMFIFO-1:0]         empty,
    output logic [NUMFIFO-1:0]         full,
    input  logic [$clog2(NUMFIFO)-1:0] st_prt,
    output logic [$clog2(NUMELEM):0]   st_cnt
);

    localparam int unsigned PW    = $clog2(NUMFIFO);
    localparam int unsigned AW    = $clog2(NUMELEM);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = NUMFIFO * NUMELEM;
    localparam logic [CW-1:0] FullCnt = CW'(NUMELEM);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        init_idx_q, init_idx_d;
    logic [BITDATA-1:0]   mem_q [DEPTH];
    logic [AW-1:0]        head_q [NUMFIFO];
    logic [AW-1:0]        head_d [NUMFIFO];
    logic [CW-1:0]        cnt_q [NUMFIFO];
    logic [CW-1:0]        cnt_d [NUMFIFO];
    logic [NUMFIFO-1:0]   empty_q, empty_d, full_q, full_d;
    logic [CW-1:0]        st_cnt_q, st_cnt_d;
    logic                 pu_err_q, po_err_q;
    logic [DAT_DELAY-1:0] vld_q;
    logic [BITDATA-1:0]   dat_q [DAT_DELAY];

    logic                 push_hit, pop_hit;
    logic [AW-1:0]        tail;
    logic [PW+AW-1:0]     push_addr, pop_addr;

    assign ready = !rst && (state_q == StRun);

    // A full queue still takes a push when the same queue is popped this cycle.
    always_comb begin
        pop_hit   = ready && pop && (cnt_q[po_prt] != '0);
        push_hit  = ready && push &&
                    ((cnt_q[pu_prt] != FullCnt) || (pop_hit && (po_prt == pu_prt)));
        tail      = head_q[pu_prt] + cnt_q[pu_prt][AW-1:0];
        push_addr = {pu_prt, tail};
        pop_addr  = {po_prt, head_q[po_prt]};
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            StInit: begin
                init_idx_d = init_idx_q + PW'(1);
                if (init_idx_q == PW'(NUMFIFO - 1)) state_d = StRun;
            end
            StRun: state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        for (int q = 0; q < NUMFIFO; q++) begin
            head_d[q] = head_q[q];
            cnt_d[q]  = cnt_q[q];
            if (state_q == StInit) begin
                if (init_idx_q == PW'(q)) begin
                    head_d[q] = '0;
                    cnt_d[q]  = '0;
                end
            end else begin
                if (pop_hit && (po_prt == PW'(q))) head_d[q] = head_q[q] + AW'(1);
                unique case ({push_hit && (pu_prt == PW'(q)), pop_hit && (po_prt == PW'(q))})
                    2'b10:   cnt_d[q] = cnt_q[q] + CW'(1);
                    2'b01:   cnt_d[q] = cnt_q[q] - CW'(1);
                    default: cnt_d[q] = cnt_q[q];
                endcase
            end
            empty_d[q] = (cnt_d[q] == '0);
            full_d[q]  = (cnt_d[q] == FullCnt);
        end
        // Unswept queues hold stale counts, so status is pinned until the sweep ends.
        if (state_q == StInit) begin
            empty_d  = '1;
            full_d   = '0;
            st_cnt_d = '0;
        end else begin
            st_cnt_d = cnt_d[st_prt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            empty_q    <= '1;
            full_q     <= '0;
            st_cnt_q   <= '0;
            pu_err_q   <= 1'b0;
            po_err_q   <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            st_cnt_q   <= st_cnt_d;
            pu_err_q   <= ready && push && !push_hit;
            po_err_q   <= ready && pop && !pop_hit;
            vld_q[0]   <= pop_hit;
            for (int i = 1; i < DAT_DELAY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Storage, pointers and data pipeline carry no reset; the sweep restores pointers.
    always_ff @(posedge clk) begin
        head_q   <= head_d;
        cnt_q    <= cnt_d;
        dat_q[0] <= mem_q[pop_addr];
        for (int i = 1; i < DAT_DELAY; i++) dat_q[i] <= dat_q[i-1];
        if (push_hit) mem_q[push_addr] <= pu_din;
    end

    assign po_vld  = !rst && vld_q[DAT_DELAY-1];
    assign po_dout = po_vld ? dat_q[DAT_DELAY-1] : '0;
    assign pu_err  = !rst && pu_err_q;
    assign po_err  = !rst && po_err_q;
    assign empty   = rst ? '1 : empty_q;
    assign full    = rst ? '0 : full_q;
    assign st_cnt  = rst ? '0 : st_cnt_q;

endmodule

// File: tb/tb_mq_static_fifo.sv
// Directed bench for mq_static_fifo at default parameters: reset sweep, fill/drain, full
// push+pop, empty pop+push, wrap with interleaved queues, and reset over an in-flight pop.
module tb_mq_static_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready;
    logic       push = 1'b0;
    logic [2:0] pu_prt = '0;
    logic [7:0] pu_din = '0;
    logic       pop = 1'b0;
    logic [2:0] po_prt = '0;
    logic       po_vld;
    logic [7:0] po_dout;
    logic       pu_err, po_err;
    logic [7:0] empty, full;
    logic [2:0] st_prt = '0;
    logic [2:0] st_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mq_static_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .push    (push),
        .pu_prt  (pu_prt),
        .pu_din  (pu_din),
        .pop     (pop),
        .po_prt  (po_prt),
        .po_vld  (po_vld),
        .po_dout (po_dout),
        .pu_err  (pu_err),
        .po_err  (po_err),
        .empty   (empty),
        .full    (full),
        .st_prt  (st_prt),
        .st_cnt  (st_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic pu, input logic [2:0] pq, input logic [7:0] d,
                           input logic po, input logic [2:0] oq);
        push = pu; pu_prt = pq; pu_din = d; pop = po; po_prt = oq;
    endtask

    initial begin
        // Reset held for one edge
        tick();
        check("rst_ready", ready, 0);
        check("rst_empty", empty, 8'hFF);
        check("rst_full", full, 0);
        check("rst_po_vld", po_vld, 0);
        check("rst_po_dout", po_dout, 0);
        check("rst_st_cnt", st_cnt, 0);
        check("rst_errs", {pu_err, po_err}, 0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("sweep_ready", ready, (i == 8) ? 1 : 0);
        end
        check("sweep_empty", empty, 8'hFF);
        check("sweep_full", full, 0);

        // Fill queue 3, overflow, drain
        st_prt = 3'd3;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 3, 8'hA1 + 8'(i), 0, 0);
            tick();
            check("q3_fill_cnt", st_cnt, i + 1);
        end
        check("q3_full", full, 8'h08);
        check("q3_not_empty", empty, 8'hF7);
        set_req(1, 3, 8'hA5, 0, 0);
        tick();
        check("q3_pu_err", pu_err, 1);
        check("q3_cnt_after_err", st_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            set_req(0, 0, 0, 1, 3);
            tick();
            if (i == 0) check("q3_pu_err_pulse", pu_err, 0);
            check("q3_po_vld", po_vld, 1);
            check("q3_po_dout", po_dout, 8'hA1 + 8'(i));
        end
        check("q3_drained", empty, 8'hFF);
        check("q3_drained_full", full, 0);
        set_req(0, 0, 0, 0, 0);
        tick();
        check("idle_po_vld", po_vld, 0);
        check("idle_po_dout", po_dout, 0);

        // Full queue 5: push and pop together are both accepted
        st_prt = 3'd5;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 5, 8'h50 + 8'(i), 0, 0);
            tick();
        end
        check("q5_full", full, 8'h20);
        set_req(1, 5, 8'h55, 1, 5);
        tick();
        check("q5_pp_vld", po_vld, 1);
        check("q5_pp_dout", po_dout, 8'h50);
        check("q5_pp_no_err", pu_err, 0);
        check("q5_pp_cnt", st_cnt, 4);
        check("q5_pp_full", full, 8'h20);
        for (int i = 0; i < 4; i++) begin
            set_req(0, 0, 0, 1, 5);
            tick();
            check("q5_drain_dout", po_dout, (i == 3) ? 8'h55 : 8'h51 + 8'(i));
        end
        check("q5_empty", empty, 8'hFF);

        // Empty queue 2: pop rejected, same-cycle push accepted
        st_prt = 3'd2;
        set_req(1, 2, 8'h22, 1, 2);
        tick();
        check("q2_po_err", po_err, 1);
        check("q2_no_vld", po_vld, 0);
        check("q2_cnt", st_cnt, 1);
        set_req(0, 0, 0, 1, 2);
        tick();
        check("q2_po_err_pulse", po_err, 0);
        check("q2_pop_vld", po_vld, 1);
        check("q2_pop_dout", po_dout, 8'h22);
        check("q2_cnt_zero", st_cnt, 0);

        // Queues 7 and 0 cycling through several wraps
        set_req(1, 7, 8'h70, 0, 0);
        tick();
        set_req(1, 0, 8'hC0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_req(1, 7, 8'h71 + 8'(i), 1, 7);
            tick();
            check("q7_wrap_vld", po_vld, 1);
            check("q7_wrap_dout", po_dout, 8'h70 + 8'(i));
            set_req(1, 0, 8'hC1 + 8'(i), 1, 0);
            tick();
            check("q0_wrap_dout", po_dout, 8'hC0 + 8'(i));
        end
        // Push and pop on different queues in one cycle
        st_prt = 3'd0;
        set_req(1, 0, 8'hCB, 1, 7);
        tick();
        check("cross_dout", po_dout, 8'h7A);
        check("cross_cnt_q0", st_cnt, 2);
        set_req(0, 0, 0, 1, 0);
        tick();
        check("q0_tail1", po_dout, 8'hCA);
        tick();
        check("q0_tail2", po_dout, 8'hCB);
        check("all_empty", empty, 8'hFF);

        // Reset lands in the cycle after a pop
        st_prt = 3'd1;
        set_req(1, 1, 8'h11, 0, 0);
        tick();
        set_req(0, 0, 0, 1, 1);
        tick();
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0);
        #1;
        check("rst_mid_po_vld", po_vld, 0);
        check("rst_mid_ready", ready, 0);
        tick();
        check("rst_mid_po_vld2", po_vld, 0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("resweep_ready", ready, (i == 8) ? 1 : 0);
            check("resweep_po_vld", po_vld, 0);
        end
        check("resweep_empty", empty, 8'hFF);
        check("resweep_cnt", st_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
